// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU arbiter/sequencer and its issue logic.
// Opcode names are the encoding the external 8-bit ALU decodes.
package alu_ctrl_pkg;

    localparam int unsigned DW_DEFAULT = 8;
    localparam int unsigned OPW        = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [OPW-1:0] OP_AND_R = 4'h0;
    localparam logic [OPW-1:0] OP_OR_R  = 4'h1;
    localparam logic [OPW-1:0] OP_XOR_R = 4'h2;
    localparam logic [OPW-1:0] OP_AND   = 4'h3;
    localparam logic [OPW-1:0] OP_OR    = 4'h4;
    localparam logic [OPW-1:0] OP_XOR   = 4'h5;
    localparam logic [OPW-1:0] OP_NAND  = 4'h6;
    localparam logic [OPW-1:0] OP_NOR   = 4'h7;
    localparam logic [OPW-1:0] OP_XNOR  = 4'h8;
    localparam logic [OPW-1:0] OP_SUB   = 4'h9;
    localparam logic [OPW-1:0] OP_ADD   = 4'hA;
    localparam logic [OPW-1:0] OP_INC   = 4'hB;
    localparam logic [OPW-1:0] OP_SHR   = 4'hC;
    localparam logic [OPW-1:0] OP_SHL   = 4'hD;
    localparam logic [OPW-1:0] OP_MUL   = 4'hE;
    localparam logic [OPW-1:0] OP_NOT   = 4'hF;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: a lone request wins outright, on a tie the
// requester named by ptr wins. Purely combinational.
module rr_arb2
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       win
);

    always_comb begin
        win = 1'b0;
        unique case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ptr;
            default: win = 1'b0;
        endcase
        gnt = (|req) ? onehot2(win) : 2'b00;
    end

endmodule

// File: rtl/alu_arb_ctrl.sv
// Round-robin arbiter and sequencer in front of the shared combinational ALU:
// accept one op, hold ALU inputs for an execute cycle, return the result.
module alu_arb_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [7:0]      req_op,
    input  logic [2*DW-1:0] req_a,
    input  logic [2*DW-1:0] req_b,
    output logic [1:0]      rsp_valid,
    input  logic [1:0]      rsp_ready,
    output logic [2*DW-1:0] rsp_data,
    output logic [3:0]      alu_op,
    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    input  logic [DW-1:0]   alu_x,
    input  logic [DW-1:0]   alu_y,
    output logic            busy
);

    state_e          state_q, state_d;
    logic            ptr_q;
    logic            gnt_q;
    logic [3:0]      op_q;
    logic [DW-1:0]   a_q, b_q;
    logic [2*DW-1:0] data_q;

    logic [1:0]      arb_req, arb_gnt;
    logic            arb_win;
    logic            accept, rsp_fire;
    logic [3:0]      op_sel;
    logic [DW-1:0]   a_sel, b_sel;

    // Masking the arbiter input keeps req_ready low outside IDLE and during reset.
    assign arb_req = (state_q == IDLE && !rst) ? req_valid : 2'b00;

    rr_arb2 u_arb (
        .req (arb_req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .win (arb_win)
    );

    assign accept   = |arb_gnt;
    assign op_sel   = arb_win ? req_op[7:4]      : req_op[3:0];
    assign a_sel    = arb_win ? req_a[2*DW-1:DW] : req_a[DW-1:0];
    assign b_sel    = arb_win ? req_b[2*DW-1:DW] : req_b[DW-1:0];
    assign rsp_fire = (state_q == RESP) && rsp_ready[gnt_q];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            gnt_q   <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= op_sel;
                a_q   <= a_sel;
                b_q   <= b_sel;
                gnt_q <= arb_win;
            end
            if (state_q == EXEC) begin
                data_q <= {alu_y, alu_x};
            end
            if (rsp_fire) begin
                ptr_q <= ~gnt_q;
            end
        end
    end

    assign req_ready = arb_gnt;
    assign rsp_valid = (state_q == RESP) ? onehot2(gnt_q) : 2'b00;
    assign rsp_data  = data_q;
    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Bench for alu_arb_ctrl: a stand-in ALU, a transaction-level reference model
// compared every cycle, directed scenarios with literal results, then random traffic.
module tb_alu_arb_ctrl;
    import alu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [7:0]  req_op = 8'h00;
    logic [15:0] req_a = 16'h0000;
    logic [15:0] req_b = 16'h0000;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b00;
    logic [15:0] rsp_data;
    logic [3:0]  alu_op;
    logic [7:0]  alu_a, alu_b, alu_x, alu_y;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit start = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arb_ctrl #(.DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .busy      (busy)
    );

    // Stand-in ALU; unnamed opcodes mix the opcode in so a wrong opcode shows up.
    function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        case (op)
            OP_ADD:  return 16'(a) + 16'(b);
            OP_SUB:  return 16'(a) - 16'(b);
            OP_MUL:  return 16'(a) * 16'(b);
            OP_XOR:  return {8'h00, a ^ b};
            OP_SHL:  return 16'(a) << b[3:0];
            default: return {a + {4'h0, op}, b ^ {op, op}};
        endcase
    endfunction

    logic [15:0] alu_res;
    assign alu_res = alu_fn(alu_op, alu_a, alu_b);
    assign alu_x   = alu_res[7:0];
    assign alu_y   = alu_res[15:8];

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: one outstanding op, age 1 = executing, age 2 = awaiting response.
    bit          m_busy  = 1'b0;
    int          m_age   = 0;
    logic        m_owner = 1'b0;
    logic        m_ptr   = 1'b0;
    logic [3:0]  m_op    = 4'h0;
    logic [7:0]  m_a     = 8'h00;
    logic [7:0]  m_b     = 8'h00;
    logic [15:0] m_data  = 16'h0000;

    function automatic logic [1:0] pick(input logic [1:0] v, input logic p);
        if (v == 2'b11) return p ? 2'b10 : 2'b01;
        return v;
    endfunction

    initial begin : monitor
        logic [1:0] e_ready, e_rv;
        wait (start);
        forever begin
            @(negedge clk);
            e_ready = (rst || m_busy) ? 2'b00 : pick(req_valid, m_ptr);
            e_rv    = (m_busy && m_age == 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
            cmp("req_ready", 16'(req_ready), 16'(e_ready));
            cmp("rsp_valid", 16'(rsp_valid), 16'(e_rv));
            cmp("busy",      16'(busy),      16'(m_busy));
            cmp("alu_op",    16'(alu_op),    16'(m_op));
            cmp("alu_a",     16'(alu_a),     16'(m_a));
            cmp("alu_b",     16'(alu_b),     16'(m_b));
            cmp("rsp_data",  rsp_data,       m_data);
            if (rst) begin
                m_busy = 1'b0; m_ptr = 1'b0; m_op = 4'h0;
                m_a = 8'h00; m_b = 8'h00; m_data = 16'h0000;
            end else if (m_busy) begin
                if (m_age == 1) begin
                    m_age  = 2;
                    m_data = alu_fn(m_op, m_a, m_b);
                end else if (rsp_ready[m_owner]) begin
                    m_busy = 1'b0;
                    m_ptr  = ~m_owner;
                end
            end else if (e_ready != 2'b00) begin
                m_busy  = 1'b1;
                m_age   = 1;
                m_owner = e_ready[1];
                m_op    = m_owner ? req_op[7:4] : req_op[3:0];
                m_a     = m_owner ? req_a[15:8] : req_a[7:0];
                m_b     = m_owner ? req_b[15:8] : req_b[7:0];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_accept(output logic [1:0] g);
        g = 2'b00;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req_ready != 2'b00) begin
                g = req_ready;
                return;
            end
            tick();
        end
        n_err++;
        $display("FAIL accept_timeout at cycle %0d: req_ready stayed 00, required a grant", cyc);
    endtask

    task automatic wait_rsp(output logic [1:0] rv, output logic [15:0] d);
        rv = 2'b00;
        d  = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (rsp_valid != 2'b00) begin
                rv = rsp_valid;
                d  = rsp_data;
                return;
            end
            tick();
        end
        n_err++;
        $display("FAIL rsp_timeout at cycle %0d: rsp_valid stayed 00, required a response", cyc);
    endtask

    initial begin : stim
        logic [1:0]  g, rv, acc;
        logic [15:0] d;
        int          last;

        tick();
        tick();
        start = 1'b1;
        rst   = 1'b0;

        // Add on requester 0
        req_op = {4'h0, OP_ADD}; req_a = 16'h00FF; req_b = 16'h0001;
        rsp_ready = 2'b11; req_valid = 2'b01;
        wait_accept(g);
        cmp("add_gnt", 16'(g), 16'h0001);
        tick();
        req_valid = 2'b00;
        #1 cmp("add_exec_no_rsp", 16'(rsp_valid), 16'h0000);
        tick();
        #1 cmp("add_rsp_valid", 16'(rsp_valid), 16'h0001);
        cmp("add_rsp_data", rsp_data, 16'h0100);
        tick();

        // Contention with both requesters held valid: grants alternate 0,1,0
        do_reset();
        req_op = {OP_XOR, OP_MUL}; req_a = 16'hAA0F; req_b = 16'hFF11;
        req_valid = 2'b11;
        wait_accept(g);
        cmp("cont_gnt_first", 16'(g), 16'h0001);
        tick();
        wait_rsp(rv, d);
        cmp("cont_rsp0_valid", 16'(rv), 16'h0001);
        cmp("cont_rsp0_data", d, 16'h00FF);
        tick();
        wait_accept(g);
        cmp("cont_gnt_second", 16'(g), 16'h0002);
        tick();
        wait_rsp(rv, d);
        cmp("cont_rsp1_valid", 16'(rv), 16'h0002);
        cmp("cont_rsp1_data", d, 16'h0055);
        tick();
        wait_accept(g);
        cmp("cont_gnt_third", 16'(g), 16'h0001);
        tick();
        req_valid = 2'b00;
        wait_rsp(rv, d);
        cmp("cont_rsp2_data", d, 16'h00FF);
        tick();

        // Response backpressure while requester 1 waits
        do_reset();
        req_op = {OP_XOR, OP_ADD}; req_a = 16'hAAFF; req_b = 16'hFF01;
        rsp_ready = 2'b00; req_valid = 2'b01;
        wait_accept(g);
        tick();
        req_valid = 2'b10;
        wait_rsp(rv, d);
        cmp("bp_rsp_valid", 16'(rv), 16'h0001);
        cmp("bp_rsp_data", d, 16'h0100);
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            cmp("bp_hold_valid", 16'(rsp_valid), 16'h0001);
            cmp("bp_hold_data", rsp_data, 16'h0100);
            cmp("bp_hold_busy", 16'(busy), 16'h0001);
            cmp("bp_hold_ready", 16'(req_ready), 16'h0000);
        end
        rsp_ready = 2'b01;
        tick();
        wait_accept(g);
        cmp("bp_next_gnt", 16'(g), 16'h0002);
        rsp_ready = 2'b11;
        tick();
        req_valid = 2'b00;
        wait_rsp(rv, d);
        cmp("bp_next_valid", 16'(rv), 16'h0002);
        cmp("bp_next_data", d, 16'h0055);
        tick();

        // Reset mid-EXEC, after a req0 op has moved ptr to 1
        req_op = {OP_SHL, OP_XOR}; req_a = 16'h81AA; req_b = 16'h01FF;
        req_valid = 2'b01;
        wait_accept(g);
        tick();
        req_valid = 2'b00;
        wait_rsp(rv, d);
        tick();
        req_valid = 2'b10;
        wait_accept(g);
        tick();
        req_valid = 2'b11;
        rst = 1'b1;
        #1 cmp("rst_blocks_ready", 16'(req_ready), 16'h0000);
        tick();
        rst = 1'b0;
        req_valid = 2'b00;
        #1;
        cmp("rst_busy", 16'(busy), 16'h0000);
        cmp("rst_rsp_valid", 16'(rsp_valid), 16'h0000);
        cmp("rst_rsp_data", rsp_data, 16'h0000);
        cmp("rst_alu_op", 16'(alu_op), 16'h0000);
        cmp("rst_alu_a", 16'(alu_a), 16'h0000);
        cmp("rst_alu_b", 16'(alu_b), 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1 cmp("rst_no_rsp", 16'(rsp_valid), 16'h0000);
        end
        req_valid = 2'b11;
        wait_accept(g);
        cmp("rst_ptr_zero", 16'(g), 16'h0001);
        tick();
        req_valid = 2'b00;
        wait_rsp(rv, d);
        tick();

        // Requester 1 streaming shift-left four times
        do_reset();
        req_op = {OP_SHL, 4'h0}; req_a = 16'h8100; req_b = 16'h0100;
        req_valid = 2'b10;
        last = 0;
        for (int i = 0; i < 4; i++) begin
            wait_accept(g);
            cmp("stream_gnt", 16'(g), 16'h0002);
            if (i > 0) cmp("stream_gap", 16'(cyc - last), 16'd3);
            last = cyc;
            tick();
            wait_rsp(rv, d);
            cmp("stream_data", d, 16'h0102);
            tick();
        end
        req_valid = 2'b00;

        // Random traffic obeying hold-until-ready
        acc = 2'b00;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < 2; k++) begin
                if (!req_valid[k] || acc[k]) begin
                    req_valid[k]     = ($urandom_range(0, 2) != 0);
                    req_op[k*4 +: 4] = 4'($urandom);
                    req_a[k*8 +: 8]  = 8'($urandom);
                    req_b[k*8 +: 8]  = 8'($urandom);
                end
            end
            rsp_ready = 2'($urandom);
            #1 acc = req_ready;
            tick();
        end
        rst = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        for (int i = 0; i < 6; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
